// File: rtl/oai_filt_pkg.sv
// Shared definitions for the deglitched OAI112 lane array.
// Holds the lane counter width function and the lane reset value.
package oai_filt_pkg;

    localparam logic OAI_RST_VAL = 1'b1;

    // Counter width able to hold 0..FILT_CYC-1, never narrower than one bit.
    function automatic int cnt_w(input int filt_cyc);
        int w;
        w = 1;
        if (filt_cyc > 1) begin
            w = $clog2(filt_cyc + 1);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/oai112_filt_lane.sv
// One lane: OAI112 gate, raw sample register, stability counter, filtered output.
// Optional sticky "o fell" flag when OAI_STICKY_EN is defined.
module oai112_filt_lane
    import oai_filt_pkg::*;
#(
    parameter int FILT_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a1,
    input  logic b1,
    input  logic c1,
    input  logic c2,
    output logic raw_q,
    output logic o,
    output logic chg
`ifdef OAI_STICKY_EN
    ,
    output logic sticky_low,
    input  logic sticky_clr
`endif
);

    localparam int              CNT_W = cnt_w(FILT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FILT_CYC - 1);

    if (FILT_CYC < 1) begin : g_bad_filt
        $error("oai112_filt_lane: FILT_CYC must be >= 1");
    end

    logic             raw_r, raw_nxt_s;
    logic             o_r, o_nxt_s;
    logic             chg_r, chg_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    // Next-state for raw sample, counter and filtered output.
    always_comb begin
        raw_nxt_s = raw_r;
        o_nxt_s   = o_r;
        chg_nxt_s = 1'b0;
        cnt_nxt_s = cnt_r;
        if (en) begin
            raw_nxt_s = ~(a1 & b1 & (c1 | c2));
            if (raw_r == o_r) begin
                cnt_nxt_s = {CNT_W{1'b0}};
            end else if (cnt_r == LAST) begin
                o_nxt_s   = raw_r;
                cnt_nxt_s = {CNT_W{1'b0}};
                chg_nxt_s = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_r <= OAI_RST_VAL;
            o_r   <= OAI_RST_VAL;
            chg_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            raw_r <= raw_nxt_s;
            o_r   <= o_nxt_s;
            chg_r <= chg_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign raw_q = raw_r;
    assign o     = o_r;
    assign chg   = chg_r;

`ifdef OAI_STICKY_EN
    logic sticky_r, sticky_nxt_s;

    // A fall of o wins over a simultaneous clear.
    always_comb begin
        sticky_nxt_s = sticky_r;
        if (en) begin
            if (o_r && !o_nxt_s) begin
                sticky_nxt_s = 1'b1;
            end else if (sticky_clr) begin
                sticky_nxt_s = 1'b0;
            end else begin
                sticky_nxt_s = sticky_r;
            end
        end else begin
            sticky_nxt_s = sticky_r;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_nxt_s;
        end
    end

    assign sticky_low = sticky_r;
`endif

endmodule

// File: rtl/oai112_filt_array.sv
// WIDTH independent deglitched OAI112 lanes: o = filtered ~(a1 & b1 & (c1 | c2)).
// Optional per-lane sticky "o fell" flags when OAI_STICKY_EN is defined.
module oai112_filt_array
    import oai_filt_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FILT_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] raw_q,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] chg
`ifdef OAI_STICKY_EN
    ,
    output logic [WIDTH-1:0] sticky_low,
    input  logic             sticky_clr
`endif
);

    if (WIDTH < 1) begin : g_bad_width
        $error("oai112_filt_array: WIDTH must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        oai112_filt_lane #(
            .FILT_CYC(FILT_CYC)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .a1        (a1[i]),
            .b1        (b1[i]),
            .c1        (c1[i]),
            .c2        (c2[i]),
            .raw_q     (raw_q[i]),
            .o         (o[i]),
            .chg       (chg[i])
`ifdef OAI_STICKY_EN
            ,
            .sticky_low(sticky_low[i]),
            .sticky_clr(sticky_clr)
`endif
        );
    end

endmodule

// File: tb/tb_oai112_filt_array.sv
// Directed bench for oai112_filt_array (FILT_CYC=4) plus a FILT_CYC=1 instance.
module tb_oai112_filt_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] a1  = 8'h00;
    logic [7:0] b1  = 8'h00;
    logic [7:0] c1  = 8'h00;
    logic [7:0] c2  = 8'h00;
    logic [7:0] raw_q, o, chg;
    logic [7:0] raw_q1, o1, chg1;
`ifdef OAI_STICKY_EN
    logic       sticky_clr = 1'b0;
    logic [7:0] sticky_low, sticky_low1;
`endif

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] raw1_m = 8'hFF;
    logic [7:0] o1_m   = 8'hFF;
    logic [7:0] chg1_m = 8'h00;

    always #5 clk = ~clk;

    oai112_filt_array #(.WIDTH(8), .FILT_CYC(4)) dut (
        .clk(clk), .rst(rst), .en(en),
        .a1(a1), .b1(b1), .c1(c1), .c2(c2),
        .raw_q(raw_q), .o(o), .chg(chg)
`ifdef OAI_STICKY_EN
        , .sticky_low(sticky_low), .sticky_clr(sticky_clr)
`endif
    );

    oai112_filt_array #(.WIDTH(8), .FILT_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .a1(a1), .b1(b1), .c1(c1), .c2(c2),
        .raw_q(raw_q1), .o(o1), .chg(chg1)
`ifdef OAI_STICKY_EN
        , .sticky_low(sticky_low1), .sticky_clr(sticky_clr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock from a negedge to the next; FILT_CYC=1 instance tracked by a model.
    task automatic step();
        logic [7:0] nraw;
        nraw   = en ? ~(a1 & b1 & (c1 | c2)) : raw1_m;
        chg1_m = en ? (raw1_m ^ o1_m) : 8'h00;
        o1_m   = en ? raw1_m : o1_m;
        raw1_m = nraw;
        @(posedge clk);
        @(negedge clk);
        chk("f1_raw", {24'd0, raw_q1}, {24'd0, raw1_m});
        chk("f1_o", {24'd0, o1}, {24'd0, o1_m});
        chk("f1_chg", {24'd0, chg1}, {24'd0, chg1_m});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-count: lane0 raw low, cnt reaches 2, then async reset.
        a1[0] = 1'b1; b1[0] = 1'b1; c1[0] = 1'b1;
        repeat (3) step();
        chk("pre_rst_raw", {24'd0, raw_q}, 32'h0000_00FE);
        #2 rst = 1'b1;
        #1;
        chk("rst_raw", {24'd0, raw_q}, 32'h0000_00FF);
        chk("rst_o", {24'd0, o}, 32'h0000_00FF);
        chk("rst_chg", {24'd0, chg}, 32'h0000_0000);
        chk("rst_raw1", {24'd0, raw_q1}, 32'h0000_00FF);
`ifdef OAI_STICKY_EN
        chk("rst_sticky", {24'd0, sticky_low}, 32'h0000_0000);
`endif
        raw1_m = 8'hFF; o1_m = 8'hFF; chg1_m = 8'h00;
        @(negedge clk);
        rst = 1'b0;

        // Latency: lane0 inputs already high, sampled at edge k.
        step();
        chk("lat_raw_k", {24'd0, raw_q}, 32'h0000_00FE);
        chk("lat_o_k", {24'd0, o}, 32'h0000_00FF);
        repeat (3) step();
        chk("lat_o_k3", {24'd0, o}, 32'h0000_00FF);
        chk("lat_chg_k3", {24'd0, chg}, 32'h0000_0000);
        step();
        chk("lat_o_k4", {24'd0, o}, 32'h0000_00FE);
        chk("lat_chg_k4", {24'd0, chg}, 32'h0000_0001);
        step();
        chk("lat_chg_k5", {24'd0, chg}, 32'h0000_0000);

        // Return lane0 high, then a 3-clock glitch that must be swallowed.
        a1[0] = 1'b0; b1[0] = 1'b0; c1[0] = 1'b0;
        repeat (5) step();
        chk("back_high", {24'd0, o}, 32'h0000_00FF);
        a1[0] = 1'b1; b1[0] = 1'b1; c1[0] = 1'b1;
        repeat (3) step();
        a1[0] = 1'b0; b1[0] = 1'b0; c1[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("glitch3_o", {24'd0, o}, 32'h0000_00FF);
            chk("glitch3_chg", {24'd0, chg}, 32'h0000_0000);
        end

        // 4-clock pulse: o falls, then rises 4 clocks later.
        a1[0] = 1'b1; b1[0] = 1'b1; c1[0] = 1'b1;
        repeat (4) step();
        a1[0] = 1'b0; b1[0] = 1'b0; c1[0] = 1'b0;
        step();
        chk("pulse4_fall", {24'd0, o}, 32'h0000_00FE);
        chk("pulse4_chg", {24'd0, chg}, 32'h0000_0001);
        repeat (3) step();
        chk("pulse4_hold", {24'd0, o}, 32'h0000_00FE);
        step();
        chk("pulse4_rise", {24'd0, o}, 32'h0000_00FF);
        chk("pulse4_chg2", {24'd0, chg}, 32'h0000_0001);

        // Freeze with count at its last value, then one enabled edge.
        a1[0] = 1'b1; b1[0] = 1'b1; c1[0] = 1'b1;
        step();
        chk("frz_raw", {24'd0, raw_q}, 32'h0000_00FE);
        repeat (3) step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_o", {24'd0, o}, 32'h0000_00FF);
            chk("frz_chg", {24'd0, chg}, 32'h0000_0000);
        end
        chk("frz_raw_hold", {24'd0, raw_q}, 32'h0000_00FE);
        en = 1'b1;
        step();
        chk("frz_resume_o", {24'd0, o}, 32'h0000_00FE);
        chk("frz_resume_chg", {24'd0, chg}, 32'h0000_0001);

        // Lane independence: lanes 0,3,7 start on staggered edges.
        a1 = 8'h00; b1 = 8'h00; c1 = 8'h00; c2 = 8'h00;
        repeat (5) step();
        chk("ind_idle", {24'd0, o}, 32'h0000_00FF);
        a1 = 8'h61; b1 = 8'h21; c1 = 8'h41; c2 = 8'h40;
        step();
        a1[3] = 1'b1; b1[3] = 1'b1; c2[3] = 1'b1;
        step();
        a1[7] = 1'b1; b1[7] = 1'b1; c1[7] = 1'b1; c2[7] = 1'b1;
        step();
        chk("ind_raw", {24'd0, raw_q}, 32'h0000_0076);
        step();
        chk("ind_o_e3", {24'd0, o}, 32'h0000_00FF);
        step();
        chk("ind_o_e4", {24'd0, o}, 32'h0000_00FE);
        chk("ind_chg_e4", {24'd0, chg}, 32'h0000_0001);
        step();
        chk("ind_o_e5", {24'd0, o}, 32'h0000_00F6);
        chk("ind_chg_e5", {24'd0, chg}, 32'h0000_0008);
        step();
        chk("ind_o_e6", {24'd0, o}, 32'h0000_0076);
        chk("ind_chg_e6", {24'd0, chg}, 32'h0000_0080);
        step();
        chk("ind_chg_e7", {24'd0, chg}, 32'h0000_0000);

`ifdef OAI_STICKY_EN
        // Sticky: lane2 falls on the same edge as a clear; set wins.
        chk("stk_before", {24'd0, sticky_low}, 32'h0000_0089);
        a1[2] = 1'b1; b1[2] = 1'b1; c1[2] = 1'b1;
        repeat (4) step();
        sticky_clr = 1'b1;
        step();
        chk("stk_o", {24'd0, o}, 32'h0000_0072);
        chk("stk_setwins", {24'd0, sticky_low}, 32'h0000_0004);
        step();
        chk("stk_clr", {24'd0, sticky_low}, 32'h0000_0000);
        sticky_clr = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
